ahb_slave_regbank: RTL and testbench
====================================

// Module: ahb_slave_regbank
// PURPOSE
//  Parametrised AHB-Lite slave register bank: NUM_REGS read/write registers plus one read-only
//  status word. Full address/data-phase pipelining, programmable wait states, byte-lane writes,
//  and two-cycle ERROR response. Sits behind the AHB decoder and replaces fixed 8-bit interfaces.
// PARAMETERS
//  DATA_WIDTH   32  bus/register width; legal values 8, 16, 32
//  NUM_REGS      4  R/W registers, indices 0..NUM_REGS-1; status word at index NUM_REGS
//  ADDR_WIDTH    8  haddr width; must be >= clog2(NUM_REGS+1)+BB, BB=log2(DATA_WIDTH/8)
//  WAIT_STATES   0  hreadyout-low cycles inserted on every OKAY data phase (0..15)
//  RESET_VAL     0  reset value of every R/W register
// PORTS
//  hclk       in   1                    bus clock, all state on rising edge
//  hreset     in   1                    asynchronous, active-high reset
//  hsel       in   1                    slave select from decoder
//  haddr      in   ADDR_WIDTH           byte address
//  htrans     in   2                    IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  hwrite     in   1                    1=write, 0=read
//  hsize      in   3                    transfer size = 2^hsize bytes
//  hwdata     in   DATA_WIDTH           write data (data phase)
//  hready     in   1                    global bus ready (previous transfer completing)
//  status_in  in   DATA_WIDTH           value returned for status index reads
//  hreadyout  out  1                    slave ready
//  hresp      out  1                    0=OKAY, 1=ERROR
//  hrdata     out  DATA_WIDTH           read data
//  reg_out    out  NUM_REGS*DATA_WIDTH  flattened registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//  wr_pulse   out  NUM_REGS             1-cycle strobe in the cycle after register i is written
// BEHAVIOUR
//  Reset: hreadyout=1, hresp=0, hrdata=0, wr_pulse=0, all regs=RESET_VAL, FSM=IDLE, no pending phase.
//  Address phase accepted when hsel & hready & htrans[1]; latch index=haddr[ADDR_WIDTH-1:BB],
//   byte offset=haddr[BB-1:0], hsize, hwrite. IDLE/BUSY or hsel=0: no data phase, OKAY, no effect.
//  Error check at acceptance: index>NUM_REGS; write to index NUM_REGS; hsize>BB; offset not
//   aligned to 2^hsize. Any hit -> ERR1.
//  FSM: IDLE  : accepted OK -> WAIT if WAIT_STATES>0 (counter=WAIT_STATES) else stay IDLE, data
//               phase completes next cycle with hreadyout=1.
//       WAIT  : hreadyout=0, hresp=0; decrement; at counter==1 -> IDLE (completion cycle follows).
//       ERR1  : hreadyout=0, hresp=1 -> ERR2.   ERR2: hreadyout=1, hresp=1 -> IDLE.
//   New address phase may be accepted in the completion cycle of previous OK/ERR2 (pipelined).
//  Writes: commit on rising edge ending the completion cycle, using hwdata then present; only
//   bytes [offset .. offset+2^hsize-1] updated; other lanes hold. wr_pulse[index]=1 next cycle.
//  Reads: hrdata = reg[index] (or status_in) during completion cycle; 0 in all other cycles.
//   Read in the phase immediately after a write to same index returns new value.
//  Erroring transfers never modify registers or pulse wr_pulse; hrdata=0.
//  SEQ treated as NONSEQ (each beat independently checked; wait states apply per beat).
//  hready low from another slave: no acceptance; pending state unaffected.
//  Reset mid-transfer (WAIT/ERR1/ERR2): transfer abandoned, no write, outputs to reset values.
// TESTING (DATA_WIDTH=32, NUM_REGS=4, RESET_VAL=0 unless stated)
//  1 Reset pulse -> hreadyout=1, hresp=0, hrdata=0, reg_out=0, wr_pulse=0.
//  2 NONSEQ write 0xDEADBEEF @0x04, then read @0x04 back-to-back -> reg1=0xDEADBEEF,
//    wr_pulse[1] 1 cycle, hrdata=0xDEADBEEF, zero wait, hresp=0.
//  3 Byte write hsize=0 @0x06 hwdata=0x00AA0000 -> reg1=0xDEAABEEF; halfword hsize=1 @0x05 -> ERROR.
//  4 Write @0x10 (status) and read @0x14 -> each: cycle1 hreadyout=0/hresp=1, cycle2 1/1; regs unchanged.
//  5 WAIT_STATES=2, 4-beat INCR read burst 0x00..0x0C -> each beat 2 cycles hreadyout=0, then data.
//  6 WAIT_STATES=3, write 0x12345678 @0x08, hreset during 2nd wait cycle -> reg2=0, no wr_pulse.

Source files
------------

// File: rtl/ahb_slave_regbank.sv
// AHB-Lite slave register bank: NUM_REGS byte-lane writable registers plus a
// read-only status word at index NUM_REGS. Address and data phases overlap;
// each OKAY data phase can be stretched by WAIT_STATES cycles, and illegal
// accesses get the two-cycle ERROR response without touching any register.
module ahb_slave_regbank #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 4,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic                           hsel,
  input  logic [ADDR_WIDTH-1:0]          haddr,
  input  logic [1:0]                     htrans,
  input  logic                           hwrite,
  input  logic [2:0]                     hsize,
  input  logic [DATA_WIDTH-1:0]          hwdata,
  input  logic                           hready,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic                           hreadyout,
  output logic                           hresp,
  output logic [DATA_WIDTH-1:0]          hrdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int BB   = $clog2(NB);
  localparam int OFFW = (BB > 0) ? BB : 1;
  localparam int IDXW = $clog2(NUM_REGS + 1);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t state, state_nxt;
  logic [3:0] wait_cnt;

  // Latched address phase waiting for its data phase to complete
  logic            dp_vld;
  logic [IDXW-1:0] dp_idx;
  logic [OFFW-1:0] dp_off;
  logic [2:0]      dp_size;
  logic            dp_write;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  accept;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] a_idx_full;
  logic [OFFW-1:0]       a_off;
  logic [7:0]            a_align_mask;
  logic                  completing;
  logic                  do_write;
  logic [NB-1:0]         lane_en;
  logic [NUM_REGS-1:0]   reg_sel;
  logic                  trans_unused;

  // htrans[0] only separates SEQ from NONSEQ / BUSY from IDLE; both pairs behave alike here
  assign trans_unused = htrans[0];

  // A new address phase is only taken while this slave is itself ready
  assign accept       = hsel & hready & htrans[1] & hreadyout;
  assign a_idx_full   = haddr >> BB;
  assign a_off        = (BB > 0) ? haddr[OFFW-1:0] : '0;
  assign a_align_mask = (8'd1 << hsize) - 8'd1;
  assign addr_err     = (a_idx_full > ADDR_WIDTH'(NUM_REGS))
                      | (hwrite & (a_idx_full == ADDR_WIDTH'(NUM_REGS)))
                      | (hsize > 3'(BB))
                      | ((8'(a_off) & a_align_mask) != 8'd0);

  // The completion cycle is the IDLE-state cycle that still owns a pending OKAY phase
  assign completing = (state == S_IDLE) & dp_vld;
  assign do_write   = completing & dp_write;

  // Byte lanes covered by the pending transfer, and which register it targets
  always_comb begin
    lane_en = '0;
    reg_sel = '0;
    for (int b = 0; b < NB; b++) begin
      lane_en[b] = (b >= int'(dp_off)) && (b < int'(dp_off) + (1 << dp_size));
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_sel[i] = do_write && (dp_idx == IDXW'(i));
    end
  end

  // FSM state register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ERR2: begin
        if (accept) begin
          if (addr_err)             state_nxt = S_ERR1;
          else if (WAIT_STATES > 0) state_nxt = S_WAIT;
          else                      state_nxt = S_IDLE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT:  if (wait_cnt <= 4'd1) state_nxt = S_IDLE;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: ready and response follow the state directly
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      S_WAIT:  hreadyout = 1'b0;
      S_ERR1:  begin hreadyout = 1'b0; hresp = 1'b1; end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
  end

  // Wait-state counter and pending-phase flag
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wait_cnt <= 4'd0;
      dp_vld   <= 1'b0;
    end else begin
      if (accept && !addr_err)  wait_cnt <= WS;
      else if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
      if (accept)               dp_vld <= ~addr_err;
      else if (completing)      dp_vld <= 1'b0;
    end
  end

  // Address-phase attributes carried into the data phase
  always_ff @(posedge hclk) begin
    if (accept) begin
      dp_idx   <= a_idx_full[IDXW-1:0];
      dp_off   <= a_off;
      dp_size  <= hsize;
      dp_write <= hwrite;
    end
  end

  // Register storage: commit enabled byte lanes at the end of the completion cycle
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_sel[i]) begin
          for (int b = 0; b < NB; b++) begin
            if (lane_en[b]) regs[i][8*b +: 8] <= hwdata[8*b +: 8];
          end
        end
      end
    end
  end

  // One-cycle strobe following each committed register write
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) wr_pulse <= '0;
    else        wr_pulse <= reg_sel;
  end

  // Read data is driven only in a read completion cycle, zero otherwise
  always_comb begin
    hrdata = '0;
    if (completing && !dp_write) begin
      if (dp_idx == IDXW'(NUM_REGS)) hrdata = status_in;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dp_idx == IDXW'(i)) hrdata = regs[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
    end
  endgenerate

endmodule

// File: tb/tb_ahb_slave_regbank.sv
// Bench for ahb_slave_regbank: three instances (0, 2 and 3 wait states) share
// one bus driver; the selected instance is checked every cycle against a
// transfer-level model of the register contents and response timing.
`timescale 1ns/1ps
module tb_ahb_slave_regbank;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int CW = NR * DW;

  logic          hclk = 1'b0;
  logic          hreset;
  logic          hsel_bus;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] status_in;
  logic          hready_force;
  logic          hready;
  int            cur;

  logic          ro0, ro1, ro2, rs0, rs1, rs2;
  logic [DW-1:0] rd0, rd1, rd2;
  logic [CW-1:0] rg0, rg1, rg2;
  logic [NR-1:0] wp0, wp1, wp2;
  logic          ro_m, rs_m;
  logic [DW-1:0] rd_m;
  logic [CW-1:0] rg_m;
  logic [NR-1:0] wp_m;

  always #5 hclk = ~hclk;

  always_comb begin
    case (cur)
      1:       begin ro_m = ro1; rs_m = rs1; rd_m = rd1; rg_m = rg1; wp_m = wp1; end
      2:       begin ro_m = ro2; rs_m = rs2; rd_m = rd2; rg_m = rg2; wp_m = wp2; end
      default: begin ro_m = ro0; rs_m = rs0; rd_m = rd0; rg_m = rg0; wp_m = wp0; end
    endcase
  end
  assign hready = ro_m & hready_force;

  ahb_slave_regbank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_bus && (cur == 0)), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready), .status_in(status_in),
    .hreadyout(ro0), .hresp(rs0), .hrdata(rd0), .reg_out(rg0), .wr_pulse(wp0));

  ahb_slave_regbank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_bus && (cur == 1)), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready), .status_in(status_in),
    .hreadyout(ro1), .hresp(rs1), .hrdata(rd1), .reg_out(rg1), .wr_pulse(wp1));

  ahb_slave_regbank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_bus && (cur == 2)), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready), .status_in(status_in),
    .hreadyout(ro2), .hresp(rs2), .hrdata(rd2), .reg_out(rg2), .wr_pulse(wp2));

  // Reference model state
  logic [DW-1:0] m_regs [3][NR];
  int            ws [3] = '{0, 2, 3};
  int            total = 0;
  int            bad = 0;
  logic          exp_ro, exp_rs;
  logic [DW-1:0] exp_rd;
  logic [NR-1:0] exp_wp;

  // Transfer table for the next sequence
  logic [AW-1:0] tq_addr  [16];
  logic          tq_wr    [16];
  logic [2:0]    tq_size  [16];
  logic [DW-1:0] tq_wdata [16];
  logic          tq_seq   [16];

  // Write waiting to land in the model at the next clock edge
  logic          pc_vld = 1'b0;
  int            pc_idx, pc_off, pc_nb;
  logic [DW-1:0] pc_data;

  function automatic bit is_err(input logic [AW-1:0] a, input logic w, input logic [2:0] s);
    int idx, off;
    idx = int'(a) / 4;
    off = int'(a) % 4;
    return (idx > NR) || (w && idx == NR) || (s > 3'd2) || ((off % (1 << s)) != 0);
  endfunction

  function automatic logic [DW-1:0] model_read(input int idx);
    return (idx == NR) ? status_in : m_regs[cur][idx];
  endfunction

  function automatic logic [CW-1:0] model_flat();
    logic [CW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_regs[cur][i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, cur, obs, expv);
    end
  endtask

  task automatic chk_all();
    chk("hreadyout", CW'(ro_m), CW'(exp_ro));
    chk("hresp",     CW'(rs_m), CW'(exp_rs));
    chk("hrdata",    CW'(rd_m), CW'(exp_rd));
    chk("wr_pulse",  CW'(wp_m), CW'(exp_wp));
    chk("reg_out",   rg_m,      model_flat());
  endtask

  task automatic idle_exp();
    exp_ro = 1'b1;
    exp_rs = 1'b0;
    exp_rd = '0;
  endtask

  task automatic bus_idle();
    hsel_bus = 1'b0;
    htrans   = 2'b00;
    haddr    = '0;
    hwrite   = 1'b0;
    hsize    = 3'd0;
  endtask

  task automatic drive_addr(input int k);
    hsel_bus = 1'b1;
    haddr    = tq_addr[k];
    htrans   = tq_seq[k] ? 2'b11 : 2'b10;
    hwrite   = tq_wr[k];
    hsize    = tq_size[k];
  endtask

  task automatic edge_update();
    exp_wp = '0;
    if (pc_vld) begin
      for (int b = pc_off; b < pc_off + pc_nb; b++) m_regs[cur][pc_idx][8*b +: 8] = pc_data[8*b +: 8];
      exp_wp[pc_idx] = 1'b1;
      pc_vld = 1'b0;
    end
  endtask

  task automatic set_t(input int k, input logic [AW-1:0] a, input logic w, input logic [2:0] s,
                       input logic [DW-1:0] d, input logic sq);
    tq_addr[k] = a; tq_wr[k] = w; tq_size[k] = s; tq_wdata[k] = d; tq_seq[k] = sq;
  endtask

  // Back-to-back sequence of n transfers; each next address overlaps the previous completion
  task automatic run(input int n);
    bit e;
    int len;
    @(posedge hclk); edge_update(); #1;
    drive_addr(0);
    for (int k = 0; k < n; k++) begin
      e   = is_err(tq_addr[k], tq_wr[k], tq_size[k]);
      len = e ? 2 : ws[cur] + 1;
      for (int c = 0; c < len; c++) begin
        @(posedge hclk); edge_update(); #1;
        hwdata = tq_wdata[k];
        if (c == len - 1 && k + 1 < n) drive_addr(k + 1);
        else bus_idle();
        if (e) begin
          exp_ro = (c == 1);
          exp_rs = 1'b1;
          exp_rd = '0;
        end else begin
          exp_ro = (c == len - 1);
          exp_rs = 1'b0;
          exp_rd = (c == len - 1 && !tq_wr[k]) ? model_read(int'(tq_addr[k]) / 4) : '0;
          if (c == len - 1 && tq_wr[k]) begin
            pc_vld  = 1'b1;
            pc_idx  = int'(tq_addr[k]) / 4;
            pc_off  = int'(tq_addr[k]) % 4;
            pc_nb   = 1 << tq_size[k];
            pc_data = tq_wdata[k];
          end
        end
        @(negedge hclk); chk_all();
      end
    end
    @(posedge hclk); edge_update(); #1;
    bus_idle();
    idle_exp();
    @(negedge hclk); chk_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hreset       = 1'b1;
    hready_force = 1'b1;
    hwdata       = '0;
    status_in    = 32'hC0FFEE11;
    cur          = 0;
    bus_idle();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
    idle_exp();
    exp_wp = '0;

    // Reset state, during and after reset
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    for (int d = 0; d < 3; d++) begin cur = d; #1; chk_all(); end
    @(posedge hclk); #1; hreset = 1'b0;
    @(negedge hclk);
    for (int d = 0; d < 3; d++) begin cur = d; #1; chk_all(); end
    cur = 0;

    // Word write then immediate read of the same register
    set_t(0, 8'h04, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0);
    set_t(1, 8'h04, 1'b0, 3'd2, 32'h0,        1'b0);
    run(2);
    chk("reg1_word", CW'(rg_m[63:32]), CW'(32'hDEADBEEF));

    // Byte lane write, misaligned halfword error, readback
    set_t(0, 8'h06, 1'b1, 3'd0, 32'h00AA0000, 1'b0);
    set_t(1, 8'h05, 1'b1, 3'd1, 32'h11111111, 1'b0);
    set_t(2, 8'h04, 1'b0, 3'd2, 32'h0,        1'b0);
    run(3);
    chk("reg1_byte", CW'(rg_m[63:32]), CW'(32'hDEAABEEF));

    // Write to status word and read past the last index both error
    set_t(0, 8'h10, 1'b1, 3'd2, 32'h55555555, 1'b0);
    set_t(1, 8'h14, 1'b0, 3'd2, 32'h0,        1'b0);
    set_t(2, 8'h10, 1'b0, 3'd2, 32'h0,        1'b0);
    run(3);

    // IDLE-with-BUSY, deselected, and hready-low address phases have no effect
    for (int v = 0; v < 3; v++) begin
      @(posedge hclk); edge_update(); #1;
      hsel_bus     = (v != 1);
      htrans       = (v == 0) ? 2'b01 : 2'b10;
      haddr        = 8'h00;
      hwrite       = 1'b1;
      hsize        = 3'd2;
      hwdata       = 32'hFFFFFFFF;
      hready_force = (v != 2);
      @(posedge hclk); edge_update(); #1;
      bus_idle();
      hready_force = 1'b1;
      idle_exp();
      @(negedge hclk); chk_all();
      @(posedge hclk); edge_update(); #1;
      @(negedge hclk); chk_all();
    end

    // Two wait states: fill registers, then a 4-beat incrementing read burst
    cur = 1;
    for (int k = 0; k < 4; k++) set_t(k, AW'(4 * k), 1'b1, 3'd2, 32'hA0B0C0D0 + DW'(k), 1'b0);
    run(4);
    for (int k = 0; k < 4; k++) set_t(k, AW'(4 * k), 1'b0, 3'd2, 32'h0, k > 0);
    run(4);

    // Randomized traffic on every instance
    for (int d = 0; d < 3; d++) begin
      cur = d;
      for (int r = 0; r < 4; r++) begin
        int n;
        n = int'($urandom_range(3, 8));
        for (int k = 0; k < n; k++) begin
          tq_addr[k]  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 23));
          tq_wr[k]    = 1'($urandom_range(0, 1));
          tq_size[k]  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
          tq_wdata[k] = $urandom;
          tq_seq[k]   = (k > 0) && ($urandom_range(0, 1) == 1);
        end
        status_in = $urandom;
        run(n);
      end
    end

    // Three wait states: reset during the second wait cycle abandons the write
    cur = 2;
    set_t(0, 8'h08, 1'b1, 3'd2, 32'h12345678, 1'b0);
    @(posedge hclk); edge_update(); #1;
    drive_addr(0);
    @(posedge hclk); edge_update(); #1;
    bus_idle();
    hwdata = 32'h12345678;
    exp_ro = 1'b0; exp_rs = 1'b0; exp_rd = '0;
    @(negedge hclk); chk_all();
    @(posedge hclk); edge_update(); #1;
    hreset = 1'b1;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
    idle_exp();
    @(negedge hclk); chk_all();
    @(posedge hclk); edge_update(); #1;
    hreset = 1'b0;
    repeat (4) begin
      @(negedge hclk); chk_all();
      @(posedge hclk); edge_update();
    end
    #1;
    chk("reg2_after_reset", CW'(rg_m[95:64]), CW'(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
